// File: rtl/mobo_bus_ctrl.sv
// Motherboard bus controller: turns CPU READ/WRITE commands into a single
// req/ack memory transfer, reporting BUSY/DONE/ERR back on mobo_stat.
module mobo_bus_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] mobo_ctrl,
  output logic [WORD_WIDTH-1:0] mobo_stat,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [WORD_WIDTH-1:0] CTRL_READ  = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] CTRL_WRITE = WORD_WIDTH'(2);

  localparam logic [1:0] STAT_IDLE = 2'd0;
  localparam logic [1:0] STAT_BUSY = 2'd1;
  localparam logic [1:0] STAT_DONE = 2'd2;
  localparam logic [1:0] STAT_ERR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [1:0]            stat_q, stat_nxt;
  logic                  req_nxt, we_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [WORD_WIDTH-1:0] wdata_nxt, rdata_nxt;

  logic is_rd, is_wr;
  assign is_rd = (mobo_ctrl == CTRL_READ);
  assign is_wr = (mobo_ctrl == CTRL_WRITE);

  assign mobo_stat = {{(WORD_WIDTH-2){1'b0}}, stat_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stat_q    <= STAT_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stat_q    <= stat_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      cpu_rdata <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stat_nxt  = stat_q;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    rdata_nxt = cpu_rdata;
    case (state)
      S_IDLE: begin
        if (is_rd || is_wr) begin
          addr_nxt  = cpu_addr;
          wdata_nxt = cpu_wdata;
          we_nxt    = is_wr;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          stat_nxt  = STAT_BUSY;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // ack is checked first so an ack on the final allowed cycle still completes
        if (mem_ack) begin
          req_nxt   = 1'b0;
          if (!mem_we) rdata_nxt = mem_rdata;
          stat_nxt  = STAT_DONE;
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          req_nxt   = 1'b0;
          stat_nxt  = STAT_ERR;
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE, S_ERR: begin
        // command must drop to NONE before another transfer can start
        if (!(is_rd || is_wr)) begin
          stat_nxt  = STAT_IDLE;
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

endmodule

// File: doc/mobo_bus_ctrl.md
Name: mobo_bus_ctrl

Overview:
- Motherboard-side bus controller that sits directly downstream of the CPU read/write function states.
- Consumes `mobo_ctrl` (NONE/READ/WRITE) and drives `mobo_stat` (IDLE/BUSY/DONE/ERR) back to the CPU.
- Executes each transfer against a memory port that uses a req/ack handshake.
- Latches address and write data, returns read data, and aborts transfers whose ack does not arrive within a bounded number of cycles.

Parameters:
- WORD_WIDTH, `WORD_WIDTH (32): data width, and width of `mobo_ctrl`/`mobo_stat`.
- ADDR_WIDTH, 16: memory address width.
- TIMEOUT, 255: maximum cycles to wait for `mem_ack` before signalling ERR; must be >=1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mobo_ctrl  in  WORD_WIDTH  command: CTRL_NONE=0, CTRL_READ=1, CTRL_WRITE=2; other values are treated as NONE
- mobo_stat  out  WORD_WIDTH  status: STAT_IDLE=0, STAT_BUSY=1, STAT_DONE=2, STAT_ERR=3
- cpu_addr  in  ADDR_WIDTH  transfer address, sampled on command accept
- cpu_wdata  in  WORD_WIDTH  write data, sampled on command accept
- cpu_rdata  out  WORD_WIDTH  read result, valid while stat=DONE after a READ
- mem_req  out  1  memory request, held high until ack
- mem_we  out  1  1=write, 0=read; stable while mem_req=1
- mem_addr  out  ADDR_WIDTH  latched address
- mem_wdata  out  WORD_WIDTH  latched write data
- mem_rdata  in  WORD_WIDTH  read data, valid in the cycle where mem_ack=1
- mem_ack  in  1  single-cycle completion pulse from memory

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; mobo_stat=STAT_IDLE; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; cpu_rdata=0; timeout counter=0.
- State machine: IDLE, REQ, DONE, ERR. All outputs are registered.
- IDLE:
  - On mobo_ctrl=READ or WRITE: latch cpu_addr to mem_addr and cpu_wdata to mem_wdata; mem_we=(ctrl==WRITE); mem_req=1; counter=0; go REQ.
  - mobo_stat becomes BUSY in the same edge.
  - Any other ctrl value: remain IDLE.
- REQ:
  - mem_req stays 1 and mem_addr/mem_we/mem_wdata are held stable.
  - Changes to mobo_ctrl are ignored; the command was already accepted.
  - mem_ack=1: mem_req=0. If READ, cpu_rdata<=mem_rdata. mobo_stat=DONE, go DONE.
  - No ack: counter increments by 1. When counter reaches TIMEOUT-1 without an ack, the next edge sets mem_req=0, mobo_stat=ERR and goes ERR. Ack arrives at most TIMEOUT cycles after entering REQ, otherwise ERR.
  - Ack in the same cycle as the timeout edge: the ack wins and the state goes to DONE.
- DONE:
  - Holds mobo_stat=DONE and cpu_rdata until mobo_ctrl=CTRL_NONE, then mobo_stat=IDLE and go IDLE.
  - A READ/WRITE still present does not retrigger a transfer. The CPU must return ctrl to NONE first, which guarantees exactly one transfer per command.
- ERR:
  - Holds mobo_stat=ERR until mobo_ctrl=CTRL_NONE, then goes IDLE.
  - cpu_rdata is unchanged from its prior value.
- Stray mem_ack in IDLE/DONE/ERR: ignored; no state or data change.
- Minimum latency: command seen in IDLE -> BUSY the next cycle; ack in the first REQ cycle -> DONE one cycle after the ack edge.
- Throughput: one transfer per (ack latency + 3) cycles minimum, counting IDLE accept, REQ, DONE, and NONE back to IDLE.
- Reset asserted mid-transfer: immediate return to the reset values; mem_req drops asynchronously. The memory must tolerate an abandoned request.
- Counter width is clog2(TIMEOUT+1) bits and saturates; no wrap-around is possible.

Test Plan:
- Write: ctrl=WRITE, addr=0x0010, wdata=0xDEADBEEF, ack 3 cycles after req -> mem_we=1 and mem_addr/mem_wdata held stable all 3 cycles; stat goes BUSY then DONE; ctrl=NONE -> IDLE next cycle.
- Read: ctrl=READ, addr=0x00FF, ack with rdata=0x12345678 in the first REQ cycle -> cpu_rdata=0x12345678 and stat=DONE; cpu_rdata holds while ctrl stays READ for 5 cycles; exactly one mem_req assertion.
- Timeout: TIMEOUT=8, never ack -> mem_req high for exactly 8 cycles, then stat=ERR and mem_req=0; ctrl=NONE -> IDLE; cpu_rdata unchanged.
- Boundary: ack in the exact timeout cycle -> DONE, not ERR. Ack in the cycle after timeout -> ERR, and the stray ack is ignored.
- Back-to-back: WRITE 0xA5A5A5A5 to 0x0004, then NONE, then READ from 0x0004 with a memory model -> reads back 0xA5A5A5A5; ctrl=3 while IDLE -> no request issued.
- Reset: assert rst_n=0 during REQ (asynchronously, between edges) -> mem_req=0 and stat=IDLE immediately; after release, a new READ completes normally.
